// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and hazard-detection unit for a five-stage pipeline.
// Tracks the EX and MEM destinations, raises stall on hazards and registers the EX-stage mux selects.
module forward_hazard_unit #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_mem_read,
    input  logic                     forward_en,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*2-1:0]     sel_src,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } stage_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    stage_t               ex_q, ex_d;
    stage_t               mem_q;
    logic [NUM_SRC*2-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 ld_retry_q, ld_retry_d;
    logic [NUM_SRC-1:0]   match_ex, match_mem;
    logic                 load_use;

    always_comb begin
        match_ex  = '0;
        match_mem = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            match_ex[k]  = id_valid && id_src_used[k] && ex_q.valid && ex_q.wb_en &&
                           (ex_q.dest == id_src[k*REG_W +: REG_W]);
            match_mem[k] = id_valid && id_src_used[k] && mem_q.valid && mem_q.wb_en &&
                           (mem_q.dest == id_src[k*REG_W +: REG_W]);
        end
        load_use = (|match_ex) && ex_q.mem_read;
        if (flush) begin
            stall = 1'b0;
        end else if (forward_en) begin
            stall = load_use;
        end else begin
            stall = |(match_ex | match_mem);
        end
    end

    always_comb begin
        sel_d       = '0;
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        ld_retry_d  = stall && forward_en;
        if (!stall && !flush && id_valid) begin
            ex_d = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
        end
        if (!stall && !flush && forward_en) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (match_ex[k]) begin
                    sel_d[k*2 +: 2] = SEL_MEM;
                end else if (match_mem[k]) begin
                    // The instruction retried after a load-use bubble keeps the load's select.
                    sel_d[k*2 +: 2] = ld_retry_q ? SEL_MEM : SEL_WB;
                end else begin
                    sel_d[k*2 +: 2] = SEL_RF;
                end
            end
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            sel_q       <= '0;
            stall_cnt_q <= '0;
            ld_retry_q  <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            sel_q       <= sel_d;
            stall_cnt_q <= stall_cnt_d;
            ld_retry_q  <= ld_retry_d;
        end
    end

    assign sel_src   = sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: expected stall/select pushed at drive time, popped at check time.
module tb_forward_hazard_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_src;
    logic [1:0]  id_src_used;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_read;
    logic        forward_en;
    logic        flush;
    logic        stall;
    logic [3:0]  sel_src;
    logic [15:0] stall_cnt;
    logic        stall2;
    logic [3:0]  sel_src2;
    logic [1:0]  stall_cnt2;

    logic [4:0]  exp_q[$];
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;
    int          tests;
    int          fails;

    forward_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .forward_en(forward_en), .flush(flush),
        .stall(stall), .sel_src(sel_src), .stall_cnt(stall_cnt)
    );

    forward_hazard_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .forward_en(forward_en), .flush(flush),
        .stall(stall2), .sel_src(sel_src2), .stall_cnt(stall_cnt2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: inputs applied just after a rising edge; stall checked at the falling edge,
    // registered outputs checked just after the next rising edge
    task automatic step(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic [3:0] d, input logic wb,
                        input logic mr, input logic fen, input logic fl,
                        input logic exp_stall, input logic [3:0] exp_sel, input string tag);
        logic [4:0] e;
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_read = mr;
        forward_en  = fen;
        flush       = fl;
        exp_q.push_back({exp_stall, exp_sel});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".stall"}, 32'(stall), 32'(e[4]));
        @(posedge clk);
        if (e[4]) begin
            exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
        #1;
        check({tag, ".sel"}, 32'(sel_src), 32'(e[3:0]));
        check({tag, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        check({tag, ".cnt2"}, 32'(stall_cnt2), 32'(exp_cnt2));
    endtask

    task automatic idle(input string tag);
        step(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = '0;
        exp_cnt2 = '0;
        rst = 1'b1;
        id_valid = 1'b1; id_src = 8'h33; id_src_used = 2'b11; id_dest = 4'd3;
        id_wb_en = 1'b1; id_mem_read = 1'b1; forward_en = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.sel", 32'(sel_src), 32'd0);
        check("rst.cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // forwarding from EX
        step(1, 0, 0, 2'b00, 3, 1, 0, 1, 0, 0, 4'b0000, "add_r3");
        step(1, 3, 0, 2'b01, 4, 1, 0, 1, 0, 0, 4'b0001, "add_r4_use_r3");
        // load-use: one stall, retried consumer gets 01 on operand 1
        step(1, 0, 0, 2'b00, 2, 1, 1, 1, 0, 0, 4'b0000, "ldr_r2");
        step(1, 0, 2, 2'b10, 6, 1, 0, 1, 0, 1, 4'b0000, "sub_stall");
        step(1, 0, 2, 2'b10, 6, 1, 0, 1, 0, 0, 4'b0100, "sub_retry");
        step(1, 6, 0, 2'b01, 7, 0, 0, 1, 0, 0, 4'b0001, "use_r6");
        idle("idle0");
        idle("idle1");
        // MEM forwarding and EX priority, same register on both operands
        step(1, 0, 0, 2'b00, 5, 1, 0, 1, 0, 0, 4'b0000, "wr_r5");
        step(1, 0, 0, 2'b00, 7, 1, 0, 1, 0, 0, 4'b0000, "unrelated");
        step(1, 5, 5, 2'b11, 8, 0, 0, 1, 0, 0, 4'b1010, "rd_r5_mem");
        step(1, 0, 0, 2'b00, 5, 1, 0, 1, 0, 0, 4'b0000, "wr_r5_a");
        step(1, 0, 0, 2'b00, 5, 1, 0, 1, 0, 0, 4'b0000, "wr_r5_b");
        step(1, 5, 5, 2'b11, 8, 0, 0, 1, 0, 0, 4'b0101, "rd_r5_ex");
        idle("idle2");
        idle("idle3");
        // stall-only mode: two stall cycles, then select 00
        step(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 4'b0000, "so_wr_r1");
        step(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 1, 4'b0000, "so_rd_ex");
        step(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 1, 4'b0000, "so_rd_mem");
        step(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 0, 4'b0000, "so_rd_go");
        idle("idle4");
        idle("idle5");
        // no hazard: writer without write-back, reader not using the operand
        step(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 4'b0000, "so_wr_nowb");
        step(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 0, 4'b0000, "so_rd_nowb");
        step(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 4'b0000, "so_wr_r1b");
        step(1, 1, 1, 2'b00, 9, 0, 0, 0, 0, 0, 4'b0000, "so_rd_unused");
        idle("idle6");
        idle("idle7");
        // two more stall cycles so the 2-bit counter saturates
        step(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 4'b0000, "sat_wr");
        step(1, 0, 1, 2'b10, 9, 0, 0, 0, 0, 1, 4'b0000, "sat_rd0");
        step(1, 0, 1, 2'b10, 9, 0, 0, 0, 0, 1, 4'b0000, "sat_rd1");
        step(1, 0, 1, 2'b10, 9, 0, 0, 0, 0, 0, 4'b0000, "sat_rd2");
        idle("idle8");
        idle("idle9");
        // flush beats a load-use match and squashes the instruction
        step(1, 0, 0, 2'b00, 2, 1, 1, 1, 0, 0, 4'b0000, "fl_ldr");
        step(1, 2, 0, 2'b01, 3, 1, 0, 1, 1, 0, 4'b0000, "fl_use");
        step(1, 2, 0, 2'b01, 3, 1, 0, 1, 0, 0, 4'b0010, "fl_after");
        idle("idle10");
        idle("idle11");

        // reset pulse in the middle of a load-use stall
        step(1, 0, 0, 2'b00, 2, 1, 1, 1, 0, 0, 4'b0000, "mr_ldr");
        id_valid = 1'b1; id_src = 8'h02; id_src_used = 2'b01; id_dest = 4'd3;
        id_wb_en = 1'b1; id_mem_read = 1'b0; forward_en = 1'b1; flush = 1'b0;
        @(negedge clk);
        check("mr.stall_before", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mr.stall_in_rst", 32'(stall), 32'd0);
        check("mr.cnt_in_rst", 32'(stall_cnt), 32'd0);
        check("mr.cnt2_in_rst", 32'(stall_cnt2), 32'd0);
        check("mr.sel_in_rst", 32'(sel_src), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = '0;
        exp_cnt2 = '0;
        step(1, 2, 0, 2'b01, 3, 1, 0, 1, 0, 0, 4'b0000, "mr_resume");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_W, default 4, meaning register-index width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning number of source operands per instruction.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port id_valid  input  1  the ID-stage instruction is valid.
REQ-007 Port id_src  input  NUM_SRC*REG_W  source register indices; operand k occupies bits [k*REG_W +: REG_W].
REQ-008 Port id_src_used  input  NUM_SRC  bit k set means operand k is actually read.
REQ-009 Port id_dest  input  REG_W  destination register of the ID instruction.
REQ-010 Port id_wb_en  input  1  the ID instruction writes back.
REQ-011 Port id_mem_read  input  1  the ID instruction is a load.
REQ-012 Port forward_en  input  1  1 = forwarding mode; 0 = stall-only mode.
REQ-013 Port flush  input  1  branch taken; squash the ID instruction.
REQ-014 Port stall  output  1  holds PC and the IF/ID register; combinational.
REQ-015 Port sel_src  output  NUM_SRC*2  registered per-operand mux select for the EX stage: 00 = register file, 01 = MEM result, 10 = WB result.
REQ-016 Port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-017 The block SHALL track two internal stage entries, EX and MEM, each holding {valid, dest, wb_en, mem_read}.
REQ-018 An operand k SHALL match a stage when id_valid=1, id_src_used[k]=1, the stage entry is valid with wb_en=1, and its dest equals operand k.
REQ-019 In forwarding mode, stall SHALL be 1 iff some operand matches EX and the EX entry has mem_read=1 (load-use).
REQ-020 In stall-only mode, stall SHALL be 1 iff some operand matches EX or MEM.
REQ-021 Stall SHALL be 0 whenever flush=1.
REQ-022 On each clock edge, MEM SHALL take the EX entry regardless of stall.
REQ-023 EX SHALL take a bubble (valid=0) when stall=1, flush=1 or id_valid=0; otherwise it SHALL take {1, id_dest, id_wb_en, id_mem_read}.
REQ-024 On each edge without stall, sel_src[k] SHALL register 01 if operand k matches EX (forwarding mode).
REQ-025 Otherwise, on each edge without stall, sel_src[k] SHALL register 10 if operand k matches MEM (forwarding mode).
REQ-026 Otherwise, on each edge without stall, sel_src[k] SHALL register 00; EX takes priority over MEM, and results reach the EX stage with one-cycle latency, aligned with the instruction.
REQ-027 On stall, flush, or stall-only mode, every sel_src field SHALL register 00.
REQ-028 stall_cnt SHALL increment on every edge with stall=1 and SHALL saturate at all-ones without wrapping.
REQ-029 Operands SHALL be evaluated independently; two operands naming the same register SHALL receive identical selects.
REQ-030 A load-use stall SHALL last exactly one cycle; after the bubble, the load sits in MEM and the retried instruction receives select 01.

Reset
REQ-031 While rst=1, EX and MEM valid bits, sel_src and stall_cnt SHALL be 0, asynchronously.
REQ-032 stall SHALL be 0 during reset, since no stage is valid.
REQ-033 Reset deasserted mid-sequence SHALL resume from an empty pipeline, with no pre-reset hazards retained.

Verification
REQ-034 ADD r3 (wb) then ADD r4 using src0=r3, forward_en=1 -> stall=0; the next cycle sel_src[1:0]=01.
REQ-035 LDR r2 then SUB using src1=r2 -> stall=1 for one cycle, stall_cnt=1; then sel_src[3:2]=01, and EX is a bubble during the stall.
REQ-036 Writer r5, unrelated instruction, then reader of r5 -> sel=10; writer r5 twice, then reader -> sel=01 (EX priority).
REQ-037 forward_en=0, writer r1, then reader r1 -> stall=1 for two cycles, then sel=00; writer with wb_en=0 or id_src_used=0 -> no stall.
REQ-038 flush=1 together with a load-use match -> stall=0 and EX receives a bubble; rst pulse mid-stall -> stall and stall_cnt = 0 immediately.
REQ-039 CNT_W=2 with 5 stall cycles -> stall_cnt stays at 3.
